// File: rtl/mem_bank_write_arbiter.sv
// mem_bank_write_arbiter
// Shares the single write port of a multi-bank operator-state memory between
// the operator pipeline writeback (absolute priority, never stalled) and
// host register writes buffered in a small FIFO. Also sequences the memory's
// bulk clear and guards it with a watchdog.
//
// Optional feature: define MEM_ARB_HOST_AGING_EN to enable host aging. A host
// write that has waited 15 cycles at the FIFO head is then granted once in
// place of the pipeline, and the displaced pipeline write is dropped and
// counted. Without the macro the pipeline always wins and the host can starve.

module mem_bank_write_arbiter #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 18,
    parameter int NUM_BANKS     = 2,
    parameter int BANK_WIDTH    = $clog2(NUM_BANKS),
    parameter int FIFO_DEPTH    = 4,
    parameter int CLEAR_TIMEOUT = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear_req,
    output logic                      clear_busy,
    output logic                      clear_error,
    input  logic                      host_wr_valid,
    output logic                      host_wr_ready,
    input  logic [BANK_WIDTH-1:0]     host_wr_bank,
    input  logic [$clog2(DEPTH)-1:0]  host_wr_addr,
    input  logic [DATA_WIDTH-1:0]     host_wr_data,
    input  logic                      pipe_wr_valid,
    input  logic [BANK_WIDTH-1:0]     pipe_wr_bank,
    input  logic [$clog2(DEPTH)-1:0]  pipe_wr_addr,
    input  logic [DATA_WIDTH-1:0]     pipe_wr_data,
    output logic                      mem_reset_mem,
    output logic                      mem_wea,
    output logic [BANK_WIDTH-1:0]     mem_banka,
    output logic [$clog2(DEPTH)-1:0]  mem_addra,
    output logic [DATA_WIDTH-1:0]     mem_dia,
    input  logic                      mem_reset_done_pulse,
    output logic [7:0]                pipe_drop_count
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int FIFO_AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W      = FIFO_AW + 1;
    localparam int ENTRY_W    = BANK_WIDTH + ADDR_WIDTH + DATA_WIDTH;
    localparam int WD_W       = $clog2(CLEAR_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        CLEAR_START = 2'd1,
        CLEARING    = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Host write queue: storage is not reset, only the pointers are.
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               fifo_empty;
    logic               fifo_full;
    logic [ENTRY_W-1:0] fifo_head;

    logic [WD_W-1:0]    watchdog;

    logic push;
    logic grant_pipe;
    logic grant_host;
    logic drop_pipe;
    logic flush;
    logic wd_clear;
    logic wd_inc;
    logic error_next;
    logic reset_mem_next;
    logic aging_hit;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                        (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
    assign fifo_head  = fifo_mem[rd_ptr[FIFO_AW-1:0]];

    // Ready excludes clear_req so a push can never coincide with the flush.
    assign host_wr_ready = !reset && (state == IDLE) && !fifo_full && !clear_req;
    assign push          = host_wr_valid && host_wr_ready;
    assign clear_busy    = (state != IDLE);

`ifdef MEM_ARB_HOST_AGING_EN
    logic [3:0] age_cnt;

    assign aging_hit = (state == IDLE) && (age_cnt == 4'd15) && !fifo_empty && !clear_req;

    // Age of the FIFO head: counts ungranted waiting cycles in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            age_cnt <= 4'd0;
        end else if ((state != IDLE) || fifo_empty || grant_host) begin
            age_cnt <= 4'd0;
        end else if (age_cnt != 4'd15) begin
            age_cnt <= age_cnt + 4'd1;
        end
    end
`else
    assign aging_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, arbitration and clear sequencing.
    // A clear accepted in IDLE discards the queue, so the host is not granted
    // on that cycle; the pipeline still is.
    always_comb begin
        state_next     = state;
        grant_pipe     = 1'b0;
        grant_host     = 1'b0;
        drop_pipe      = 1'b0;
        flush          = 1'b0;
        wd_clear       = 1'b0;
        wd_inc         = 1'b0;
        error_next     = 1'b0;
        reset_mem_next = 1'b0;
        case (state)
            IDLE: begin
                if (aging_hit) begin
                    grant_host = 1'b1;
                    drop_pipe  = pipe_wr_valid;
                end else if (pipe_wr_valid) begin
                    grant_pipe = 1'b1;
                end else if (!fifo_empty && !clear_req) begin
                    grant_host = 1'b1;
                end
                if (clear_req) begin
                    state_next = CLEAR_START;
                    flush      = 1'b1;
                end
            end
            CLEAR_START: begin
                reset_mem_next = 1'b1;
                wd_clear       = 1'b1;
                drop_pipe      = pipe_wr_valid;
                state_next     = CLEARING;
            end
            CLEARING: begin
                drop_pipe = pipe_wr_valid;
                if (mem_reset_done_pulse) begin
                    state_next = IDLE;
                end else if (watchdog == WD_W'(CLEAR_TIMEOUT - 1)) begin
                    state_next = IDLE;
                    error_next = 1'b1;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FIFO pointers: wrap naturally, flushed when a clear is accepted.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (grant_host) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[FIFO_AW-1:0]] <= {host_wr_bank, host_wr_addr, host_wr_data};
        end
    end

    // Clear watchdog.
    always_ff @(posedge clk) begin
        if (reset || wd_clear) begin
            watchdog <= '0;
        end else if (wd_inc) begin
            watchdog <= watchdog + WD_W'(1);
        end
    end

    // Registered memory write port, one cycle after the grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_wea   <= 1'b0;
            mem_banka <= '0;
            mem_addra <= '0;
            mem_dia   <= '0;
        end else begin
            mem_wea <= grant_pipe || grant_host;
            if (grant_pipe) begin
                mem_banka <= pipe_wr_bank;
                mem_addra <= pipe_wr_addr;
                mem_dia   <= pipe_wr_data;
            end else if (grant_host) begin
                {mem_banka, mem_addra, mem_dia} <= fifo_head;
            end
        end
    end

    // Registered clear strobes: memory reset and watchdog error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_reset_mem <= 1'b0;
            clear_error   <= 1'b0;
        end else begin
            mem_reset_mem <= reset_mem_next;
            clear_error   <= error_next;
        end
    end

    // Saturating count of dropped pipeline writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_drop_count <= 8'd0;
        end else if (drop_pipe && (pipe_drop_count != 8'hFF)) begin
            pipe_drop_count <= pipe_drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_mem_bank_write_arbiter.sv
// Directed testbench for mem_bank_write_arbiter (default parameters).
// Expectations follow MEM_ARB_HOST_AGING_EN when it is defined for the build.

module tb_mem_bank_write_arbiter;

`ifdef MEM_ARB_HOST_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_req;
    logic        clear_busy;
    logic        clear_error;
    logic        host_wr_valid;
    logic        host_wr_ready;
    logic [0:0]  host_wr_bank;
    logic [4:0]  host_wr_addr;
    logic [15:0] host_wr_data;
    logic        pipe_wr_valid;
    logic [0:0]  pipe_wr_bank;
    logic [4:0]  pipe_wr_addr;
    logic [15:0] pipe_wr_data;
    logic        mem_reset_mem;
    logic        mem_wea;
    logic [0:0]  mem_banka;
    logic [4:0]  mem_addra;
    logic [15:0] mem_dia;
    logic        mem_reset_done_pulse;
    logic [7:0]  pipe_drop_count;

    int n_pass  = 0;
    int n_total = 0;

    mem_bank_write_arbiter dut (
        .clk                  (clk),
        .reset                (reset),
        .clear_req            (clear_req),
        .clear_busy           (clear_busy),
        .clear_error          (clear_error),
        .host_wr_valid        (host_wr_valid),
        .host_wr_ready        (host_wr_ready),
        .host_wr_bank         (host_wr_bank),
        .host_wr_addr         (host_wr_addr),
        .host_wr_data         (host_wr_data),
        .pipe_wr_valid        (pipe_wr_valid),
        .pipe_wr_bank         (pipe_wr_bank),
        .pipe_wr_addr         (pipe_wr_addr),
        .pipe_wr_data         (pipe_wr_data),
        .mem_reset_mem        (mem_reset_mem),
        .mem_wea              (mem_wea),
        .mem_banka            (mem_banka),
        .mem_addra            (mem_addra),
        .mem_dia              (mem_dia),
        .mem_reset_done_pulse (mem_reset_done_pulse),
        .pipe_drop_count      (pipe_drop_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_wr(input string tag, input logic [0:0] bank, input logic [4:0] addr,
                          input logic [15:0] data);
        chk({tag, "_wea"}, mem_wea, 1);
        chk({tag, "_word"}, {mem_banka, mem_addra, mem_dia}, {bank, addr, data});
    endtask

    logic [0:0]  q_bank [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [4:0]  q_addr [4] = '{5'd1, 5'd2, 5'd3, 5'd4};
    logic [15:0] q_data [4] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};

    initial begin
        reset = 1'b1; clear_req = 1'b0; mem_reset_done_pulse = 1'b0;
        host_wr_valid = 1'b0; host_wr_bank = '0; host_wr_addr = '0; host_wr_data = '0;
        pipe_wr_valid = 1'b0; pipe_wr_bank = '0; pipe_wr_addr = '0; pipe_wr_data = '0;

        // Reset state
        repeat (3) step();
        chk("rst_wea", mem_wea, 0);
        chk("rst_word", {mem_banka, mem_addra, mem_dia}, 0);
        chk("rst_ready", host_wr_ready, 0);
        chk("rst_busy", clear_busy, 0);
        chk("rst_reset_mem", mem_reset_mem, 0);
        chk("rst_error", clear_error, 0);
        chk("rst_drop", pipe_drop_count, 0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", host_wr_ready, 1);

        // Single host write, no pipe traffic: mem_wea two cycles after handshake cycle
        host_wr_valid = 1'b1; host_wr_bank = 1'b1; host_wr_addr = 5'd5; host_wr_data = 16'hBEEF;
        #1;
        chk("h1_ready", host_wr_ready, 1);
        step();
        host_wr_valid = 1'b0;
        chk("h1_n1_wea", mem_wea, 0);
        step();
        chk_wr("h1_n2", 1'b1, 5'd5, 16'hBEEF);
        step();
        chk("h1_n3_wea", mem_wea, 0);

        // Four host pushes while pipe holds the port; then drain in order
        pipe_wr_valid = 1'b1; pipe_wr_bank = 1'b0; pipe_wr_addr = 5'd3; pipe_wr_data = 16'h1111;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) chk_wr("pipe_lat", 1'b0, 5'd3, 16'h1111);
            host_wr_valid = 1'b1;
            host_wr_bank = q_bank[i]; host_wr_addr = q_addr[i]; host_wr_data = q_data[i];
            #1;
            chk("q_ready", host_wr_ready, 1);
            step();
        end
        chk("q_full_ready", host_wr_ready, 0);
        chk_wr("q_pipe_last", 1'b0, 5'd3, 16'h1111);
        host_wr_valid = 1'b0;
        pipe_wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_wr("q_drain", q_bank[i], q_addr[i], q_data[i]);
        end
        step();
        chk("q_drained_wea", mem_wea, 0);

        // Clear with two host writes queued: they are discarded
        pipe_wr_valid = 1'b1; pipe_wr_data = 16'h2222;
        host_wr_valid = 1'b1; host_wr_bank = 1'b0; host_wr_addr = 5'd10; host_wr_data = 16'hC001;
        step();
        host_wr_bank = 1'b1; host_wr_addr = 5'd11; host_wr_data = 16'hC002;
        step();
        host_wr_valid = 1'b0; pipe_wr_valid = 1'b0; clear_req = 1'b1;
        #1;
        chk("clr_req_ready", host_wr_ready, 0);
        chk("clr_idle_busy", clear_busy, 0);
        step();
        clear_req = 1'b0;
        chk("clr_start_busy", clear_busy, 1);
        chk("clr_start_rstmem", mem_reset_mem, 0);
        chk("clr_start_wea", mem_wea, 0);
        step();
        chk("clr_rstmem_hi", mem_reset_mem, 1);
        chk("clr_rstmem_busy", clear_busy, 1);
        chk("clr_rstmem_wea", mem_wea, 0);
        step();
        chk("clr_rstmem_lo", mem_reset_mem, 0);
        chk("clr_pre_done_busy", clear_busy, 1);
        mem_reset_done_pulse = 1'b1;
        step();
        mem_reset_done_pulse = 1'b0;
        chk("clr_done_busy", clear_busy, 0);
        chk("clr_done_err", clear_error, 0);
        for (int i = 0; i < 4; i++) begin
            chk("clr_flushed_wea", mem_wea, 0);
            step();
        end
        chk("clr_after_ready", host_wr_ready, 1);

        // Three pipe writes dropped during CLEARING
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        pipe_wr_valid = 1'b1; pipe_wr_bank = 1'b1; pipe_wr_addr = 5'd8; pipe_wr_data = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("drop_wea", mem_wea, 0);
        end
        pipe_wr_valid = 1'b0;
        chk("drop_cnt3", pipe_drop_count, 3);
        mem_reset_done_pulse = 1'b1;
        step();
        mem_reset_done_pulse = 1'b0;
        chk("drop_done_busy", clear_busy, 0);
        chk("drop_cnt3_hold", pipe_drop_count, 3);

        // Watchdog timeout with pipe held high: drops saturate, clear_req ignored mid-clear
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        pipe_wr_valid = 1'b1; pipe_wr_data = 16'h4444;
        chk("wd_start_err", clear_error, 0);
        step();
        for (int j = 2; j <= 257; j++) begin
            chk("wd_err_low", clear_error, 0);
            chk("wd_busy", clear_busy, 1);
            chk("wd_wea", mem_wea, 0);
            if (j == 100) chk("wd_cnt_mid", pipe_drop_count, 102);
            clear_req = (j == 50);
            step();
        end
        clear_req = 1'b0;
        chk("wd_err_pulse", clear_error, 1);
        chk("wd_idle_busy", clear_busy, 0);
        chk("wd_cnt_sat", pipe_drop_count, 255);
        pipe_wr_valid = 1'b0;
        step();
        chk("wd_err_once", clear_error, 0);
        chk("wd_idle_wea", mem_wea, 0);

        // Reset in the middle of a clear aborts it
        clear_req = 1'b1; pipe_wr_valid = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        pipe_wr_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", clear_busy, 0);
        chk("mid_rst_rstmem", mem_reset_mem, 0);
        chk("mid_rst_cnt", pipe_drop_count, 0);
        chk("mid_rst_ready", host_wr_ready, 1);
        step();
        chk("mid_rst_busy2", clear_busy, 0);

        // Pipe held high with one host write queued: starvation or aging grant
        pipe_wr_valid = 1'b1; pipe_wr_bank = 1'b0; pipe_wr_addr = 5'd7; pipe_wr_data = 16'h7777;
        host_wr_valid = 1'b1; host_wr_bank = 1'b1; host_wr_addr = 5'd9; host_wr_data = 16'hD00D;
        #1;
        chk("age_push_ready", host_wr_ready, 1);
        step();
        host_wr_valid = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            if (AGING && j == 17) chk_wr("age_host", 1'b1, 5'd9, 16'hD00D);
            else                  chk_wr("age_pipe", 1'b0, 5'd7, 16'h7777);
            step();
        end
        chk("age_cnt", pipe_drop_count, AGING ? 1 : 0);
        pipe_wr_valid = 1'b0;
        step();
        if (AGING) chk("age_after_wea", mem_wea, 0);
        else       chk_wr("starved_host", 1'b1, 5'd9, 16'hD00D);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
